dct_frame_loader: RTL and testbench

Upstream feeder for the combinational 4-point DCT (`DCT_4point`). It accepts a serial stream of 4-bit signed samples over a valid/ready handshake and assembles each group of four consecutive samples into a parallel vector `x0..x3`. Two banks form a ping-pong buffer, so one vector can be held for the DCT while the next is filling. The DCT outputs are combinational from `x0..x3`, so `out_valid` qualifies the DCT result directly.

---
 rtl/dct_pkg.sv | 8 +
 rtl/dct_loader_bank.sv | 40 ++++
 rtl/dct_frame_loader.sv | 122 ++++++++++++
 tb/tb_dct_frame_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants and sample type for the 4-point DCT datapath and its loader.
package dct_pkg;
    localparam int SAMPLE_W = 4;
    localparam int N_POINTS = 4;
    localparam int COEF_W   = 12;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/dct_loader_bank.sv
// Four-entry sample bank: one indexed write port, zero-fill from an index upward,
// and all four entries read in parallel.
module dct_loader_bank #(
    parameter int SAMPLE_W = dct_pkg::SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_we,
    input  logic [1:0]                 i_widx,
    input  logic signed [SAMPLE_W-1:0] i_wdata,
    input  logic                       i_pad,
    input  logic [1:0]                 i_pad_from,
    output logic signed [SAMPLE_W-1:0] o_d0,
    output logic signed [SAMPLE_W-1:0] o_d1,
    output logic signed [SAMPLE_W-1:0] o_d2,
    output logic signed [SAMPLE_W-1:0] o_d3
);
    import dct_pkg::*;

    logic signed [SAMPLE_W-1:0] r_mem [N_POINTS];

    // The pad start always lies above the write index, so the two never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_POINTS; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < N_POINTS; i++) begin
                if (i_pad && (2'(i) >= i_pad_from))
                    r_mem[i] <= '0;
                else if (i_we && (i_widx == 2'(i)))
                    r_mem[i] <= i_wdata;
            end
        end
    end

    assign o_d0 = r_mem[0];
    assign o_d1 = r_mem[1];
    assign o_d2 = r_mem[2];
    assign o_d3 = r_mem[3];
endmodule

// File: rtl/dct_frame_loader.sv
// Serial-to-parallel ping-pong loader feeding the 4-point DCT.
// Optional DCT_LOADER_FLUSH_EN adds flush/out_padded for zero-padding a partial vector.
module dct_frame_loader #(
    parameter int SAMPLE_W = dct_pkg::SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef DCT_LOADER_FLUSH_EN
    input  logic                       flush,
    output logic                       out_padded,
`endif
    output logic signed [SAMPLE_W-1:0] x0,
    output logic signed [SAMPLE_W-1:0] x1,
    output logic signed [SAMPLE_W-1:0] x2,
    output logic signed [SAMPLE_W-1:0] x3
);
    import dct_pkg::*;

    logic       r_wr_bank;
    logic       r_rd_bank;
    logic [1:0] r_wr_idx;
    logic [1:0] r_full;
    logic [1:0] w_full_nxt;
    logic       w_accept;
    logic       w_consume;
    logic       w_wrap;
    logic       w_flush_do;
    logic       w_complete;
    logic [1:0] w_pad_from;

    logic signed [SAMPLE_W-1:0] w_b0 [N_POINTS];
    logic signed [SAMPLE_W-1:0] w_b1 [N_POINTS];

    assign in_ready  = !r_full[r_wr_bank];
    assign out_valid = r_full[r_rd_bank];
    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;
    assign w_wrap    = w_accept && (r_wr_idx == 2'd3);

`ifdef DCT_LOADER_FLUSH_EN
    logic [1:0] r_padded;

    // A flush that coincides with the 4th sample is just a normal completion.
    assign w_flush_do = flush && !w_wrap && (w_accept || (r_wr_idx != 2'd0));
    assign w_pad_from = w_accept ? (r_wr_idx + 2'd1) : r_wr_idx;
    assign out_padded = r_padded[r_rd_bank];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_padded <= 2'b00;
        end else begin
            if (w_consume)  r_padded[r_rd_bank] <= 1'b0;
            if (w_complete) r_padded[r_wr_bank] <= w_flush_do;
        end
    end
`else
    assign w_flush_do = 1'b0;
    assign w_pad_from = r_wr_idx;
`endif

    assign w_complete = w_wrap || w_flush_do;

    // Fill completion and drain always target different banks, so both may apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_consume)  w_full_nxt[r_rd_bank] = 1'b0;
        if (w_complete) w_full_nxt[r_wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_idx  <= 2'd0;
            r_full    <= 2'b00;
        end else begin
            if (w_accept)   r_wr_idx  <= r_wr_idx + 2'd1;
            if (w_flush_do) r_wr_idx  <= 2'd0;
            if (w_complete) r_wr_bank <= ~r_wr_bank;
            if (w_consume)  r_rd_bank <= ~r_rd_bank;
            r_full <= w_full_nxt;
        end
    end

    dct_loader_bank #(.SAMPLE_W(SAMPLE_W)) u_bank0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_accept && !r_wr_bank),
        .i_widx     (r_wr_idx),
        .i_wdata    (in_sample),
        .i_pad      (w_flush_do && !r_wr_bank),
        .i_pad_from (w_pad_from),
        .o_d0       (w_b0[0]),
        .o_d1       (w_b0[1]),
        .o_d2       (w_b0[2]),
        .o_d3       (w_b0[3])
    );

    dct_loader_bank #(.SAMPLE_W(SAMPLE_W)) u_bank1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_accept && r_wr_bank),
        .i_widx     (r_wr_idx),
        .i_wdata    (in_sample),
        .i_pad      (w_flush_do && r_wr_bank),
        .i_pad_from (w_pad_from),
        .o_d0       (w_b1[0]),
        .o_d1       (w_b1[1]),
        .o_d2       (w_b1[2]),
        .o_d3       (w_b1[3])
    );

    assign x0 = r_rd_bank ? w_b1[0] : w_b0[0];
    assign x1 = r_rd_bank ? w_b1[1] : w_b0[1];
    assign x2 = r_rd_bank ? w_b1[2] : w_b0[2];
    assign x3 = r_rd_bank ? w_b1[3] : w_b0[3];
endmodule

// File: tb/tb_dct_frame_loader.sv
// Directed scoreboard bench for dct_frame_loader; exercises flush when DCT_LOADER_FLUSH_EN is defined.
module tb_dct_frame_loader;
    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [3:0] in_sample;
    logic              out_valid;
    logic              out_ready;
    logic              flush_i;
    logic              padded_o;
    logic signed [3:0] x0, x1, x2, x3;

    int checks = 0;
    int errors = 0;

    logic [16:0]       q[$];
    logic signed [3:0] part[4];
    int                cnt = 0;

    dct_frame_loader #(.SAMPLE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef DCT_LOADER_FLUSH_EN
        .flush      (flush_i),
        .out_padded (padded_o),
`endif
        .x0         (x0),
        .x1         (x1),
        .x2         (x2),
        .x3         (x3)
    );

`ifndef DCT_LOADER_FLUSH_EN
    assign padded_o = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against scoreboard, update the model, advance.
    task automatic cyc(input logic v, input logic signed [3:0] s, input logic ordy,
                       input logic fl, output logic acc);
        logic [16:0] exp_v;
        logic [16:0] obs_v;
        in_valid  = v;
        in_sample = s;
        out_ready = ordy;
        flush_i   = fl;
        #1;
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        acc = v && in_ready;
        if (out_valid && ordy && q.size() != 0) begin
            exp_v = q.pop_front();
            obs_v = {padded_o, x0, x1, x2, x3};
            chk("vector", 32'(obs_v), 32'(exp_v));
        end
        if (acc) begin
            part[cnt] = s;
            cnt++;
            if (cnt == 4) begin
                q.push_back({1'b0, part[0], part[1], part[2], part[3]});
                cnt = 0;
            end
        end
        if (fl && cnt != 0) begin
            for (int i = cnt; i < 4; i++) part[i] = 4'sd0;
            q.push_back({1'b1, part[0], part[1], part[2], part[3]});
            cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [3:0] s, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) cyc(1'b1, s, ordy, 1'b0, acc);
        chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int k = 0; k < n; k++) cyc(1'b0, 4'sd0, ordy, 1'b0, acc);
    endtask

    initial begin
        logic acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sample = 4'sd0;
        out_ready = 1'b0;
        flush_i   = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_x", 32'({x0, x1, x2, x3}), 32'd0);
        chk("rst_padded", 32'(padded_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic vector with downstream always ready
        for (int i = 1; i <= 4; i++) send(4'(i), 1'b1);
        idle(3, 1'b1);

        // Extreme signed values
        send(-4'sd8, 1'b1);
        send(4'sd7, 1'b1);
        send(-4'sd1, 1'b1);
        send(4'sd0, 1'b1);
        idle(2, 1'b1);

        // Back-pressure: both banks fill, 9th sample stalls
        for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
        cyc(1'b1, 4'sd1, 1'b0, 1'b0, acc);
        chk("stall9_a", 32'(acc), 32'd0);
        cyc(1'b1, 4'sd1, 1'b0, 1'b0, acc);
        chk("stall9_b", 32'(acc), 32'd0);
        send(-4'sd7, 1'b1);
        send(-4'sd6, 1'b1);
        send(-4'sd5, 1'b1);
        send(-4'sd4, 1'b1);
        idle(3, 1'b1);

        // Continuous stream: one sample accepted every cycle
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 4'(i), 1'b1, 1'b0, acc);
            chk("stream_acc", 32'(acc), 32'd1);
        end
        idle(3, 1'b1);

        // Asynchronous reset with a held vector and a partial one
        for (int i = 1; i <= 6; i++) send(4'(i), 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_x", 32'({x0, x1, x2, x3}), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        cnt = 0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(4'sd9, 1'b1);
        send(4'sd10, 1'b1);
        send(4'sd11, 1'b1);
        send(4'sd12, 1'b1);
        idle(2, 1'b1);

`ifdef DCT_LOADER_FLUSH_EN
        // Flush of a partial vector, flush alongside a sample, then a plain vector
        send(4'sd5, 1'b0);
        send(4'sd6, 1'b0);
        cyc(1'b0, 4'sd0, 1'b0, 1'b1, acc);
        idle(2, 1'b1);
        cyc(1'b1, 4'sd3, 1'b1, 1'b1, acc);
        chk("flush_acc", 32'(acc), 32'd1);
        idle(2, 1'b1);
        cyc(1'b0, 4'sd0, 1'b1, 1'b1, acc);
        for (int i = 1; i <= 3; i++) send(4'(i), 1'b1);
        cyc(1'b1, 4'sd4, 1'b1, 1'b1, acc);
        idle(2, 1'b1);
        for (int i = 5; i <= 8; i++) send(4'(i), 1'b1);
        idle(2, 1'b1);
`endif

        chk("drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
